// File: rtl/audio_tone_detect.sv
// Measures the period of a square-wave tone in i_clk cycles, with glitch rejection and loss-of-tone timeout.
// Define AUDIO_TONE_DETECT_FREQ_EN to add a restoring divider that converts the period into Hz on o_freq.
module audio_tone_detect #(
    parameter int CLK_FREQ    = 12000000,
    parameter int TIMEOUT_CYC = 600000,
    parameter int MIN_PERIOD  = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_pulse,
    output logic [23:0] o_period,
    output logic        o_valid,
    output logic        o_timeout,
    output logic [15:0] o_freq,
    output logic        o_freq_valid
);

    localparam logic [23:0] LP_TIMEOUT = 24'(TIMEOUT_CYC);
    localparam logic [23:0] LP_MIN     = 24'(MIN_PERIOD);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    logic [2:0]  r_sync;
    logic        r_edge;
    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_count;
    logic [23:0] w_count_next;
    logic [23:0] w_period_next;
    logic        w_valid_next;
    logic        w_timeout_next;

    // r_sync[1:0] is the metastability synchronizer; r_sync[2] holds the previous synchronized level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], i_pulse};
            r_edge <= r_sync[1] & ~r_sync[2];
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_period_next  = o_period;
        w_valid_next   = 1'b0;
        w_timeout_next = 1'b0;
        if (!i_enable) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_edge) begin
                        w_state_next = ST_MEASURE;
                        w_count_next = 24'd1;
                    end
                end
                ST_MEASURE: begin
                    // An edge always beats a timeout; edges closer than LP_MIN are glitches and keep counting.
                    if (r_edge && (r_count >= LP_MIN)) begin
                        w_period_next = r_count;
                        w_valid_next  = 1'b1;
                        w_count_next  = 24'd1;
                    end else if (!r_edge && (r_count == LP_TIMEOUT)) begin
                        w_state_next   = ST_IDLE;
                        w_period_next  = '0;
                        w_timeout_next = 1'b1;
                        w_count_next   = '0;
                    end else begin
                        w_count_next = r_count + 24'd1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            o_period  <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            o_period  <= w_period_next;
            o_valid   <= w_valid_next;
            o_timeout <= w_timeout_next;
        end
    end

`ifdef AUDIO_TONE_DETECT_FREQ_EN
    localparam logic [23:0] LP_DIVIDEND = 24'(CLK_FREQ);

    logic        r_div_busy;
    logic [4:0]  r_div_cnt;
    logic [23:0] r_rem;
    logic [23:0] r_quo;
    logic [23:0] r_divisor;
    logic [23:0] w_rem_in;
    logic [23:0] w_quo_in;
    logic [23:0] w_dsr;
    logic [24:0] w_shift;
    logic        w_ge;
    logic [23:0] w_rem_out;
    logic [23:0] w_quo_out;

    // The start cycle already performs the first quotient bit so the result lands 25 cycles after o_valid.
    always_comb begin
        w_rem_in  = r_div_busy ? r_rem     : 24'd0;
        w_quo_in  = r_div_busy ? r_quo     : LP_DIVIDEND;
        w_dsr     = r_div_busy ? r_divisor : o_period;
        w_shift   = {w_rem_in, w_quo_in[23]};
        w_ge      = (w_shift >= {1'b0, w_dsr});
        w_rem_out = w_ge ? 24'(w_shift - {1'b0, w_dsr}) : w_shift[23:0];
        w_quo_out = {w_quo_in[22:0], w_ge};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_busy   <= 1'b0;
            r_div_cnt    <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_divisor    <= '0;
            o_freq       <= '0;
            o_freq_valid <= 1'b0;
        end else begin
            o_freq_valid <= 1'b0;
            if (!r_div_busy) begin
                if (o_valid) begin
                    r_div_busy <= 1'b1;
                    r_div_cnt  <= 5'd1;
                    r_divisor  <= o_period;
                    r_rem      <= w_rem_out;
                    r_quo      <= w_quo_out;
                end
            end else if (r_div_cnt != 5'd24) begin
                r_div_cnt <= r_div_cnt + 5'd1;
                r_rem     <= w_rem_out;
                r_quo     <= w_quo_out;
            end else begin
                r_div_busy   <= 1'b0;
                o_freq       <= (|r_quo[23:16]) ? 16'hFFFF : r_quo[15:0];
                o_freq_valid <= 1'b1;
            end
            if (w_timeout_next) begin
                o_freq <= '0;
            end
        end
    end
`else
    logic w_unused_clk_freq;
    assign w_unused_clk_freq = ^(24'(CLK_FREQ));
    assign o_freq            = '0;
    assign o_freq_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_audio_tone_detect.sv
// Randomized scoreboard bench for audio_tone_detect; a timestamp-based edge model predicts every strobe.
// Honours AUDIO_TONE_DETECT_FREQ_EN the same way the design does.
module tb_audio_tone_detect;

   localparam int CLK_FREQ    = 12000000;
   localparam int TIMEOUT_CYC = 27400;
   localparam int MIN_PERIOD  = 32;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_enable = 1'b1;
   logic        i_pulse = 1'b0;
   logic [23:0] o_period;
   logic        o_valid;
   logic        o_timeout;
   logic [15:0] o_freq;
   logic        o_freq_valid;

   audio_tone_detect #(
      .CLK_FREQ   (CLK_FREQ),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .MIN_PERIOD (MIN_PERIOD)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_enable    (i_enable),
      .i_pulse     (i_pulse),
      .o_period    (o_period),
      .o_valid     (o_valid),
      .o_timeout   (o_timeout),
      .o_freq      (o_freq),
      .o_freq_valid(o_freq_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int value;
      int due;
   } expItem_t;

   expItem_t periodQ[$];
   expItem_t freqQ[$];
   expItem_t timeoutQ[$];
   expItem_t monItem;

   int total = 0;
   int bad   = 0;

   bit prevP      = 1'b0;
   bit haveRef    = 1'b0;
   int lastEdge   = 0;
   int heldPeriod = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model in terms of sample timestamps: a rising edge sampled at cycle s is
   // accepted when it lies at least MIN_PERIOD after the last accepted edge, reported 3 cycles later.
   task automatic modelStep(input int s, input bit p, input bit en);
      bit edgeNow;
      int d;
      edgeNow = p && !prevP;
      prevP   = p;
      if (!en) begin
         haveRef = 1'b0;
         return;
      end
      if (edgeNow) begin
         if (!haveRef) begin
            haveRef  = 1'b1;
            lastEdge = s;
         end else if (s - lastEdge >= MIN_PERIOD) begin
            d = s - lastEdge;
            periodQ.push_back('{d, s + 3});
            heldPeriod = d;
`ifdef AUDIO_TONE_DETECT_FREQ_EN
            freqQ.push_back('{((CLK_FREQ / d) > 65535) ? 65535 : (CLK_FREQ / d), s + 28});
`endif
            lastEdge = s;
         end
      end else if (haveRef && (s - lastEdge == TIMEOUT_CYC)) begin
         timeoutQ.push_back('{0, s + 3});
         haveRef    = 1'b0;
         heldPeriod = 0;
      end
   endtask

   task automatic applyStimulus(input bit p, input bit en, input int n);
      repeat (n) begin
         @(negedge clk);
         i_pulse  = p;
         i_enable = en;
         modelStep(cyc + 1, p, en);
      end
   endtask

   task automatic squareWave(input int hi, input int lo, input int n);
      repeat (n) begin
         applyStimulus(1'b1, 1'b1, hi);
         applyStimulus(1'b0, 1'b1, lo);
      end
   endtask

   // Reset asserted between clock edges; outputs must clear before the next edge arrives.
   task automatic doReset();
      @(posedge clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("rstPeriod", int'(o_period), 0);
      checkOutput("rstValid", int'(o_valid), 0);
      checkOutput("rstTimeout", int'(o_timeout), 0);
      checkOutput("rstFreq", int'(o_freq), 0);
      checkOutput("rstFreqValid", int'(o_freq_valid), 0);
      periodQ.delete();
      freqQ.delete();
      timeoutQ.delete();
      haveRef    = 1'b0;
      prevP      = 1'b0;
      heldPeriod = 0;
      @(negedge clk);
      i_rst_n = 1'b1;
      modelStep(cyc + 1, i_pulse, i_enable);
   endtask

   // Monitor: every strobe pops the matching expectation; expectations left past their due cycle are missed strobes.
   always @(negedge clk) begin
      if (i_rst_n) begin
         if (o_valid) begin
            if (periodQ.size() == 0) begin
               checkOutput("spuriousValid", int'(o_valid), 0);
            end else begin
               monItem = periodQ.pop_front();
               checkOutput("period", int'(o_period), monItem.value);
               checkOutput("validCycle", cyc, monItem.due);
`ifndef AUDIO_TONE_DETECT_FREQ_EN
               checkOutput("freqTied", int'(o_freq), 0);
`endif
            end
         end
         if (o_timeout) begin
            if (timeoutQ.size() == 0) begin
               checkOutput("spuriousTimeout", int'(o_timeout), 0);
            end else begin
               monItem = timeoutQ.pop_front();
               checkOutput("timeoutPeriod", int'(o_period), 0);
               checkOutput("timeoutCycle", cyc, monItem.due);
               checkOutput("timeoutFreq", int'(o_freq), 0);
            end
         end
         if (o_freq_valid) begin
            if (freqQ.size() == 0) begin
               checkOutput("spuriousFreqValid", int'(o_freq_valid), 0);
            end else begin
               monItem = freqQ.pop_front();
               checkOutput("freq", int'(o_freq), monItem.value);
               checkOutput("freqCycle", cyc, monItem.due);
            end
         end
         if (periodQ.size() != 0 && periodQ[0].due < cyc) begin
            monItem = periodQ.pop_front();
            checkOutput("validMissing", cyc, monItem.due);
         end
         if (timeoutQ.size() != 0 && timeoutQ[0].due < cyc) begin
            monItem = timeoutQ.pop_front();
            checkOutput("timeoutMissing", cyc, monItem.due);
         end
         if (freqQ.size() != 0 && freqQ[0].due < cyc) begin
            monItem = freqQ.pop_front();
            checkOutput("freqMissing", cyc, monItem.due);
         end
      end
   end

   // Bound on total run time so a stuck design still produces a report.
   initial begin
      #1200000;
      $display("[TB] FAIL watchdog: actual=%0d required<%0d cycles", cyc, 120000);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1;
      checkOutput("initPeriod", int'(o_period), 0);
      checkOutput("initValid", int'(o_valid), 0);
      checkOutput("initTimeout", int'(o_timeout), 0);
      checkOutput("initFreq", int'(o_freq), 0);
      checkOutput("initFreqValid", int'(o_freq_valid), 0);
      @(negedge clk);
      i_rst_n = 1'b1;
      modelStep(cyc + 1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 10);

      $display("[TB] 500/500 square wave");
      squareWave(500, 500, 4);

      $display("[TB] glitch 10 cycles after each true edge");
      repeat (3) begin
         applyStimulus(1'b1, 1'b1, 3);
         applyStimulus(1'b0, 1'b1, 7);
         applyStimulus(1'b1, 1'b1, 490);
         applyStimulus(1'b0, 1'b1, 500);
      end

      $display("[TB] reset mid-measurement");
      applyStimulus(1'b1, 1'b1, 400);
      doReset();
      applyStimulus(1'b1, 1'b1, 499);
      applyStimulus(1'b0, 1'b1, 500);
      squareWave(500, 500, 2);

      $display("[TB] period 100 saturates frequency");
      squareWave(50, 50, 6);

      $display("[TB] enable low with toggling input");
      applyStimulus(1'b0, 1'b1, 20);
      repeat (5000) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b0, 1'b1, 10);
      checkOutput("heldPeriod", int'(o_period), heldPeriod);

      $display("[TB] random high/low lengths");
      repeat (15) begin
         applyStimulus(1'b1, 1'b1, int'($urandom_range(1, 300)));
         applyStimulus(1'b0, 1'b1, int'($urandom_range(1, 300)));
      end

      $display("[TB] 440 Hz tone then loss of tone");
      applyStimulus(1'b1, 1'b1, 13637);
      applyStimulus(1'b0, 1'b1, 13637);
      applyStimulus(1'b1, 1'b1, 100);
      applyStimulus(1'b0, 1'b1, TIMEOUT_CYC + 20);
      squareWave(50, 50, 2);

      applyStimulus(1'b0, 1'b1, 60);
      checkOutput("pendingValid", periodQ.size(), 0);
      checkOutput("pendingTimeout", timeoutQ.size(), 0);
      checkOutput("pendingFreq", freqQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
